// File: rtl/score_display_driver.sv
// Binary score to DIGITS-digit BCD converter (shift-add-3, one bit per clock) with
// registered active-low 7-segment outputs. Define BLANK_LZ_EN to blank leading zeros.
module score_display_driver #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  load,
  input  logic [BIN_W-1:0]      binValue,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcdDigits,
  output logic [7*DIGITS-1:0]   hexDisplay
);

  function automatic longint unsigned pow10_m1(input int unsigned d);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < d; i++) r = r * 10;
    return r - 1;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  localparam longint unsigned MAX_VAL = pow10_m1(DIGITS);
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t                  state, state_next;
  logic [BIN_W-1:0]        bin_sr;
  logic [4*DIGITS-1:0]     bcd_acc;
  logic [4*DIGITS-1:0]     bcd_adj;
  logic [4*DIGITS+BIN_W-1:0] shifted;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    ovf_pend;
  logic [4*DIGITS-1:0]     bcd_final;
  logic [7*DIGITS-1:0]     hex_next;
  logic                    lead;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (load) state_next = SHIFT;
      end
      SHIFT:   if (bit_cnt == LAST_CNT) state_next = UPDATE;
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd_acc;
    for (int unsigned k = 0; k < DIGITS; k++)
      if (bcd_acc[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_acc[4*k +: 4] + 4'd3;
    // Top-digit carry falls off the left end, as intended.
    shifted = {bcd_adj, bin_sr} << 1;
  end

  always_comb begin
    bcd_final = bcd_acc;
    hex_next  = '1;
    lead      = 1'b1;
    if (ovf_pend) begin
      bcd_final = {DIGITS{4'h9}};
      hex_next  = {DIGITS{7'b0111111}};
    end else begin
      for (int unsigned k = 0; k < DIGITS; k++)
        hex_next[7*k +: 7] = seg7(bcd_acc[4*k +: 4]);
`ifdef BLANK_LZ_EN
      // Walk down from the top digit; the ones digit is never blanked.
      for (int unsigned i = 0; i + 1 < DIGITS; i++) begin
        if (bcd_acc[4*(DIGITS-1-i) +: 4] != 4'd0) lead = 1'b0;
        if (lead) hex_next[7*(DIGITS-1-i) +: 7] = '1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bin_sr     <= '0;
      bcd_acc    <= '0;
      bit_cnt    <= '0;
      ovf_pend   <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      bcdDigits  <= '0;
      hexDisplay <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load) begin
          bin_sr   <= binValue;
          bcd_acc  <= '0;
          bit_cnt  <= '0;
          ovf_pend <= 64'(binValue) > MAX_VAL;
        end
        SHIFT: begin
          bcd_acc <= shifted[4*DIGITS+BIN_W-1 -: 4*DIGITS];
          bin_sr  <= shifted[BIN_W-1:0];
          bit_cnt <= bit_cnt + 1'b1;
        end
        UPDATE: begin
          bcdDigits  <= bcd_final;
          hexDisplay <= hex_next;
          overflow   <= ovf_pend;
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
